mem_access_unit: RTL and testbench

Load/store sequencer between the datapath and main memory. Accepts one byte or word request at a time over a valid/ready handshake. Converts each request into single-cycle word reads and writes on main memory's 16-bit port, including read-modify-write for byte stores and two-word splits for unaligned words. Returns read data, or a write acknowledge, as a one-cycle response pulse.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_lane_merge.sv | 54 +++++
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory access unit.
//   - ADDR_W / DATA_W defaults (byte address width, memory word width)
//   - 3-bit FSM state encoding and the matching enum type
//   - request operation classes and the classifier used at accept time
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_CAPA = 3'd2;
  localparam logic [2:0] S_RDB  = 3'd3;
  localparam logic [2:0] S_CAPB = 3'd4;
  localparam logic [2:0] S_WRA  = 3'd5;
  localparam logic [2:0] S_WRB  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_RDA  = S_RDA,
    ST_CAPA = S_CAPA,
    ST_RDB  = S_RDB,
    ST_CAPB = S_CAPB,
    ST_WRA  = S_WRA,
    ST_WRB  = S_WRB,
    ST_DONE = S_DONE
  } state_t;

  localparam logic [1:0] OP_WORD_ALIGNED   = 2'd0;
  localparam logic [1:0] OP_BYTE           = 2'd1;
  localparam logic [1:0] OP_WORD_UNALIGNED = 2'd2;

  // A byte access never straddles words; only a word at an odd address does.
  function automatic logic [1:0] op_class(input logic is_byte, input logic addr_lsb);
    logic [1:0] op;
    if (is_byte) begin
      op = OP_BYTE;
    end else if (addr_lsb) begin
      op = OP_WORD_UNALIGNED;
    end else begin
      op = OP_WORD_ALIGNED;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus the word-wide memory port.
//   req_*     : datapath request (valid/ready)
//   rsp_*     : one-cycle completion pulse with load data
//   mem_read, mem_write, address, data_in : memory strobes driven by the unit
//   data_out  : memory read data, valid the cycle after mem_read
// Modports: slave = the unit, master = datapath + memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = mem_pkg::DATA_W_DEFAULT
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, address, data_in
  );

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_read, mem_write, address, data_in
  );

endinterface

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: combinational byte-lane steering shared by byte and unaligned paths.
//   i_old      : word being merged into (write) or read from (load)
//   i_prev_hi  : upper byte of the A0 word, used by unaligned word loads
//   i_new      : store data from the request
//   i_addr0    : request byte-address bit 0
//   i_byte     : 1 = byte access
//   i_half     : unaligned store half select (0 = A0 word, 1 = A1 word)
//   o_wr_word  : merged word to write
//   o_rd_word  : load result (byte loads zero-extended)
module mem_lane_merge
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0]   i_old,
  input  logic [DATA_W/2-1:0] i_prev_hi,
  input  logic [DATA_W-1:0]   i_new,
  input  logic                i_addr0,
  input  logic                i_byte,
  input  logic                i_half,
  output logic [DATA_W-1:0]   o_wr_word,
  output logic [DATA_W-1:0]   o_rd_word
);

  localparam int HB = DATA_W / 2;

  // Lane selection for store merge and load extraction (little-endian).
  always_comb begin
    o_wr_word = i_new;
    o_rd_word = i_old;
    if (i_byte) begin
      if (i_addr0) begin
        o_wr_word = {i_new[HB-1:0], i_old[HB-1:0]};
        o_rd_word = {{HB{1'b0}}, i_old[DATA_W-1:HB]};
      end else begin
        o_wr_word = {i_old[DATA_W-1:HB], i_new[HB-1:0]};
        o_rd_word = {{HB{1'b0}}, i_old[HB-1:0]};
      end
    end else if (i_addr0) begin
      // Unaligned word: low data byte lands in A0's upper lane,
      // high data byte lands in A1's lower lane.
      if (i_half) begin
        o_wr_word = {i_old[DATA_W-1:HB], i_new[DATA_W-1:HB]};
      end else begin
        o_wr_word = {i_new[HB-1:0], i_old[HB-1:0]};
      end
      o_rd_word = {i_old[HB-1:0], i_prev_hi};
    end else begin
      o_wr_word = i_new;
      o_rd_word = i_old;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the datapath and a 16-bit word memory.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_access_unit_if.slave (request, response and memory port)
// Each accepted request becomes a sequence of single-cycle word reads/writes;
// byte stores use read-modify-write and unaligned words are split over A0/A1.
// Every bus output comes straight from a register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_we;
  logic              r_addr0;
  logic [ADDR_W-1:0] r_a0;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hold_a;
  logic [DATA_W-1:0] r_hold_b;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data_in;

  logic [ADDR_W-1:0] w_a1;
  logic [ADDR_W-1:0] w_req_a0;
  logic              w_is_byte;
  logic              w_unaligned;
  logic [DATA_W-1:0] w_old;
  logic              w_half;
  logic [DATA_W-1:0] w_wr_word;
  logic [DATA_W-1:0] w_rd_word;

  // A1 wraps naturally at the top of the address space.
  assign w_a1        = r_a0 + ADDR_W'(2);
  assign w_req_a0    = {bus.req_addr[ADDR_W-1:1], 1'b0};
  assign w_is_byte   = (r_op == OP_BYTE);
  assign w_unaligned = (r_op == OP_WORD_UNALIGNED);

  // Pick the word the merge unit works on for the transition leaving this state.
  // Data captured in the current state is still on data_out, not yet in a holding register.
  always_comb begin
    w_old  = bus.data_out;
    w_half = 1'b0;
    case (r_state)
      ST_CAPA: begin
        w_old  = bus.data_out;
        w_half = 1'b0;
      end
      ST_CAPB: begin
        if (r_we) begin
          w_old  = r_hold_a;
          w_half = 1'b0;
        end else begin
          w_old  = bus.data_out;
          w_half = 1'b0;
        end
      end
      ST_WRA: begin
        w_old  = r_hold_b;
        w_half = 1'b1;
      end
      default: begin
        w_old  = bus.data_out;
        w_half = 1'b0;
      end
    endcase
  end

  mem_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .i_old     (w_old),
    .i_prev_hi (r_hold_a[DATA_W-1:DATA_W/2]),
    .i_new     (r_wdata),
    .i_addr0   (r_addr0),
    .i_byte    (w_is_byte),
    .i_half    (w_half),
    .o_wr_word (w_wr_word),
    .o_rd_word (w_rd_word)
  );

  // Sequencer FSM; output registers are loaded with the values for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WORD_ALIGNED;
      r_we        <= 1'b0;
      r_addr0     <= 1'b0;
      r_a0        <= '0;
      r_wdata     <= '0;
      r_hold_a    <= '0;
      r_hold_b    <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_address   <= '0;
      r_data_in   <= '0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_we        <= bus.req_we;
            r_addr0     <= bus.req_addr[0];
            r_a0        <= w_req_a0;
            r_wdata     <= bus.req_wdata;
            r_op        <= op_class(bus.req_byte, bus.req_addr[0]);
            r_req_ready <= 1'b0;
            r_address   <= w_req_a0;
            // Only an aligned word store needs no prior read.
            if (bus.req_we && !bus.req_byte && !bus.req_addr[0]) begin
              r_state     <= ST_WRA;
              r_mem_write <= 1'b1;
              r_data_in   <= bus.req_wdata;
            end else begin
              r_state    <= ST_RDA;
              r_mem_read <= 1'b1;
            end
          end
        end
        ST_RDA: begin
          r_state <= ST_CAPA;
        end
        ST_CAPA: begin
          r_hold_a <= bus.data_out;
          if (w_unaligned) begin
            r_state    <= ST_RDB;
            r_mem_read <= 1'b1;
            r_address  <= w_a1;
          end else if (r_we) begin
            r_state     <= ST_WRA;
            r_mem_write <= 1'b1;
            r_address   <= r_a0;
            r_data_in   <= w_wr_word;
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rd_word;
          end
        end
        ST_RDB: begin
          r_state <= ST_CAPB;
        end
        ST_CAPB: begin
          r_hold_b <= bus.data_out;
          if (r_we) begin
            r_state     <= ST_WRA;
            r_mem_write <= 1'b1;
            r_address   <= r_a0;
            r_data_in   <= w_wr_word;
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rd_word;
          end
        end
        ST_WRA: begin
          if (w_unaligned) begin
            r_state     <= ST_WRB;
            r_mem_write <= 1'b1;
            r_address   <= w_a1;
            r_data_in   <= w_wr_word;
          end else begin
            r_state     <= ST_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
          end
        end
        ST_WRB: begin
          r_state     <= ST_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_rdata <= '0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.address   = r_address;
  assign bus.data_in   = r_data_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a 1-cycle registered memory model.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic do_init;
  int   n_checks;
  int   n_fail;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];

  // Memory model: registered read data, write on strobe, preload on do_init.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 16'h0000;
      mem[0]     <= 16'h2BCD;
      mem[1]     <= 16'h1234;
      mem[32767] <= 16'hBEEF;
      bus_if.data_out <= 16'h0000;
    end else begin
      if (bus_if.mem_read)  bus_if.data_out <= mem[bus_if.address[15:1]];
      if (bus_if.mem_write) mem[bus_if.address[15:1]] <= bus_if.data_in;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  // Issue one request and observe it until the response pulse.
  task automatic run_op(input logic we, input logic bt, input logic [15:0] addr,
                        input logic [15:0] wdata,
                        output int lat, output logic [15:0] rdata,
                        output int nrd, output int nwr,
                        output logic [15:0] rda0, output logic [15:0] rda1,
                        output logic [15:0] wra0, output logic [15:0] wra1,
                        output int viol, output logic rsp_after, output logic rdy_after);
    int w;
    lat = 0; rdata = 16'h0000; nrd = 0; nwr = 0; viol = 0;
    rda0 = 16'h0000; rda1 = 16'h0000; wra0 = 16'h0000; wra1 = 16'h0000;
    rsp_after = 1'b0; rdy_after = 1'b0;
    @(negedge clk);
    bus_if.req_we    = we;
    bus_if.req_byte  = bt;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    bus_if.req_valid = 1'b1;
    w = 0;
    while (!bus_if.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus_if.req_ready) begin
      check("ready_timeout", 32'(bus_if.req_ready), 32'd1);
      bus_if.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Request is now latched; scramble the fields to prove they are ignored.
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = ~we;
    bus_if.req_byte  = ~bt;
    bus_if.req_addr  = ~addr;
    bus_if.req_wdata = ~wdata;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus_if.req_ready) viol++;
      if (bus_if.mem_read && bus_if.mem_write) viol++;
      if (bus_if.mem_read) begin
        if (nrd == 0) rda0 = bus_if.address; else rda1 = bus_if.address;
        nrd++;
      end
      if (bus_if.mem_write) begin
        if (nwr == 0) wra0 = bus_if.address; else wra1 = bus_if.address;
        nwr++;
      end
      if (bus_if.rsp_valid) begin
        lat   = k;
        rdata = bus_if.rsp_rdata;
        break;
      end
    end
    @(negedge clk);
    rsp_after = bus_if.rsp_valid;
    rdy_after = bus_if.req_ready;
  endtask

  typedef struct {
    logic        we;
    logic        bt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [15:0] chk_addr;
    logic [15:0] chk_word;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int          lat, nrd, nwr, viol;
    logic [15:0] rdata, rda0, rda1, wra0, wra1, a0;
    logic        rsp_after, rdy_after;

    n_checks = 0;
    n_fail   = 0;

    //           we    bt    addr      wdata     rdata     lat rd wr chk_addr  chk_word
    vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2BCD, 3, 1, 0, 16'h0000, 16'h2BCD};
    vecs[1]  = '{1'b0, 1'b1, 16'h0001, 16'h0000, 16'h002B, 3, 1, 0, 16'h0000, 16'h2BCD};
    vecs[2]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h00CD, 3, 1, 0, 16'h0002, 16'h1234};
    vecs[3]  = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h342B, 5, 2, 0, 16'h0002, 16'h1234};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hCDBE, 5, 2, 0, 16'hFFFE, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b1, 16'h0001, 16'h0077, 16'h0000, 4, 1, 1, 16'h0000, 16'h77CD};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h77CD, 3, 1, 0, 16'h0000, 16'h77CD};
    vecs[7]  = '{1'b1, 1'b0, 16'h0001, 16'hA55A, 16'h0000, 7, 2, 2, 16'h0000, 16'h5ACD};
    vecs[8]  = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h12A5, 3, 1, 0, 16'h0002, 16'h12A5};
    vecs[9]  = '{1'b1, 1'b0, 16'h0002, 16'hC0DE, 16'h0000, 2, 0, 1, 16'h0002, 16'hC0DE};
    vecs[10] = '{1'b1, 1'b1, 16'h0002, 16'hEE99, 16'h0000, 4, 1, 1, 16'h0002, 16'hC099};
    vecs[11] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h00C0, 5, 2, 0, 16'h0004, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h00EF, 3, 1, 0, 16'hFFFE, 16'hBEEF};
    vecs[13] = '{1'b1, 1'b0, 16'hFFFF, 16'h1357, 16'h0000, 7, 2, 2, 16'h0000, 16'h5A13};
    vecs[14] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h57EF, 3, 1, 0, 16'hFFFE, 16'h57EF};

    rst = 1'b1;
    do_init = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_byte  = 1'b0;
    bus_if.req_addr  = 16'h0000;
    bus_if.req_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_ready",     32'(bus_if.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    check("rst_strobes",   32'({bus_if.mem_read, bus_if.mem_write}), 32'd0);
    check("rst_address",   32'(bus_if.address), 32'd0);
    check("rst_data_in",   32'(bus_if.data_in), 32'd0);
    rst = 1'b0;
    do_init = 1'b0;

    for (int v = 0; v < 15; v++) begin
      run_op(vecs[v].we, vecs[v].bt, vecs[v].addr, vecs[v].wdata,
             lat, rdata, nrd, nwr, rda0, rda1, wra0, wra1, viol, rsp_after, rdy_after);
      a0 = {vecs[v].addr[15:1], 1'b0};
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rdata));
      check($sformatf("v%0d_nreads", v), 32'(nrd), 32'(vecs[v].exp_rd));
      check($sformatf("v%0d_nwrites", v), 32'(nwr), 32'(vecs[v].exp_wr));
      check($sformatf("v%0d_busy_violations", v), 32'(viol), 32'd0);
      check($sformatf("v%0d_rsp_one_cycle", v), 32'(rsp_after), 32'd0);
      check($sformatf("v%0d_ready_back", v), 32'(rdy_after), 32'd1);
      if (nrd >= 1) check($sformatf("v%0d_rd_addr0", v), 32'(rda0), 32'(a0));
      if (nrd == 2) check($sformatf("v%0d_rd_addr1", v), 32'(rda1), 32'(16'(a0 + 16'd2)));
      if (nwr >= 1) check($sformatf("v%0d_wr_addr0", v), 32'(wra0), 32'(a0));
      if (nwr == 2) check($sformatf("v%0d_wr_addr1", v), 32'(wra1), 32'(16'(a0 + 16'd2)));
      check($sformatf("v%0d_mem_word", v), 32'(rd_mem(vecs[v].chk_addr)), 32'(vecs[v].chk_word));
    end

    // Back-to-back: req_valid stays high; second request waits for DONE.
    @(negedge clk);
    check("b2b_ready_a", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_we = 1'b0; bus_if.req_byte = 1'b0;
    bus_if.req_addr = 16'h0002; bus_if.req_wdata = 16'h0000;
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_byte = 1'b1; bus_if.req_addr = 16'h0001;
    lat = 0; nrd = 0; viol = 0; rdata = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus_if.req_ready) viol++;
      if (bus_if.mem_read) nrd++;
      if (bus_if.rsp_valid) begin
        lat = k; rdata = bus_if.rsp_rdata; break;
      end
    end
    check("b2b_a_latency", 32'(lat), 32'd3);
    check("b2b_a_rdata", 32'(rdata), 32'h0000C099);
    check("b2b_a_nreads", 32'(nrd), 32'd1);
    check("b2b_a_busy", 32'(viol), 32'd0);
    @(negedge clk);
    check("b2b_ready_b", 32'(bus_if.req_ready), 32'd1);
    check("b2b_rsp_low", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    lat = 0; rdata = 16'h0000;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus_if.rsp_valid) begin
        lat = k; rdata = bus_if.rsp_rdata; break;
      end
    end
    check("b2b_b_latency", 32'(lat), 32'd3);
    check("b2b_b_rdata", 32'(rdata), 32'h0000005A);

    // Reset during CAPB of an unaligned store: abort with no write and no response.
    @(negedge clk);
    @(negedge clk);
    check("rstmid_ready", 32'(bus_if.req_ready), 32'd1);
    bus_if.req_we = 1'b1; bus_if.req_byte = 1'b0;
    bus_if.req_addr = 16'h0001; bus_if.req_wdata = 16'h1111;
    bus_if.req_valid = 1'b1;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    nrd = 0; nwr = 0; viol = 0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      if (bus_if.mem_read) nrd++;
      if (bus_if.mem_write) nwr++;
      if (bus_if.rsp_valid) viol++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_idle_ready", 32'(bus_if.req_ready), 32'd1);
    check("rstmid_strobes", 32'({bus_if.mem_read, bus_if.mem_write}), 32'd0);
    check("rstmid_address", 32'(bus_if.address), 32'd0);
    check("rstmid_data_in", 32'(bus_if.data_in), 32'd0);
    check("rstmid_rsp_rdata", 32'(bus_if.rsp_rdata), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus_if.mem_write) nwr++;
      if (bus_if.rsp_valid) viol++;
    end
    check("rstmid_nreads", 32'(nrd), 32'd2);
    check("rstmid_nwrites", 32'(nwr), 32'd0);
    check("rstmid_no_rsp", 32'(viol), 32'd0);
    check("rstmid_mem0", 32'(rd_mem(16'h0000)), 32'h00005A13);
    check("rstmid_mem2", 32'(rd_mem(16'h0002)), 32'h0000C099);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
